// File: rtl/modmul15361_sched.sv
// Round-robin front end sharing one signed multiplier and an external
// mod-15361 reducer; results return in order through a credited FIFO.
module modmul15361_sched #(
    parameter int NREQ    = 4,
    parameter int PW      = 2,
    parameter int USER_W  = 8,
    parameter int RED_LAT = 3,
    parameter int FIFO_D  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*14-1:0]       req_a,
    input  logic [NREQ*14-1:0]       req_b,
    input  logic [NREQ*USER_W-1:0]   req_user,
    output logic signed [26:0]       prod_o,
    input  logic signed [13:0]       red_i,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [13:0]       rsp_z,
    output logic [PW-1:0]            rsp_port,
    output logic [USER_W-1:0]        rsp_user
);
    localparam int TD = 2 + RED_LAT;
    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          grantIdx;
    logic                   found;
    logic                   creditOk;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          cnt;
    logic signed [13:0]     opA;
    logic signed [13:0]     opB;
    logic signed [26:0]     prodReg;
    logic                   tagV    [TD];
    logic [PW-1:0]          tagPort [TD];
    logic [USER_W-1:0]      tagUser [TD];
    logic signed [13:0]     memZ    [FIFO_D];
    logic [PW-1:0]          memPort [FIFO_D];
    logic [USER_W-1:0]      memUser [FIFO_D];
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;

    // Search for the first valid port, starting just after the last grant
    always_comb begin
        int j;
        j = 0;
        found = 1'b0;
        grantIdx = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                grantIdx = PW'(j);
            end
        end
    end

    // Grant only while every issued op still has a guaranteed FIFO slot
    always_comb begin
        creditOk = ({1'b0, inflight} + {1'b0, cnt}) < (CW + 1)'(FIFO_D);
        issue = !rst && found && creditOk;
        req_ready = '0;
        if (issue) req_ready[grantIdx] = 1'b1;
    end

    assign push      = tagV[TD-1];
    assign rsp_valid = !rst && (cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign prod_o    = prodReg;
    assign rsp_z     = rsp_valid ? memZ[rdPtr] : '0;
    assign rsp_port  = rsp_valid ? memPort[rdPtr] : '0;
    assign rsp_user  = rsp_valid ? memUser[rdPtr] : '0;

    // Remember the last granted port; reset makes port 0 win first
    always_ff @(posedge clk) begin
        if (rst) ptr <= PW'(NREQ - 1);
        else if (issue) ptr <= grantIdx;
    end

    // Operand capture, product register and tag shift pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            opA     <= '0;
            opB     <= '0;
            prodReg <= '0;
            for (int k = 0; k < TD; k++) begin
                tagV[k]    <= 1'b0;
                tagPort[k] <= '0;
                tagUser[k] <= '0;
            end
        end else begin
            if (issue) begin
                opA <= req_a[grantIdx*14 +: 14];
                opB <= req_b[grantIdx*14 +: 14];
            end
            prodReg    <= 27'(opA) * 27'(opB);
            tagV[0]    <= issue;
            tagPort[0] <= grantIdx;
            tagUser[0] <= req_user[grantIdx*USER_W +: USER_W];
            for (int k = 1; k < TD; k++) begin
                tagV[k]    <= tagV[k-1];
                tagPort[k] <= tagPort[k-1];
                tagUser[k] <= tagUser[k-1];
            end
        end
    end

    // Result storage, written when a valid tag lines up with red_i
    always_ff @(posedge clk) begin
        if (push) begin
            memZ[wrPtr]    <= red_i;
            memPort[wrPtr] <= tagPort[TD-1];
            memUser[wrPtr] <= tagUser[TD-1];
        end
    end

    // FIFO pointers, occupancy and in-flight credit bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            inflight <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) rdPtr <= rdPtr + AW'(1);
            cnt      <= cnt + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(issue) - CW'(push);
        end
    end

    // Credit makes overflow impossible; flag it if it ever happens
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && cnt == CW'(FIFO_D)));
            assert (!(pop && cnt == '0));
        end
    end
endmodule

// File: tb/tb_modmul15361_sched.sv
// Randomized and directed bench for modmul15361_sched with a
// queue-based reference model and a behavioural reduction unit.
module tb_modmul15361_sched;
    localparam int NREQ    = 4;
    localparam int PW      = 2;
    localparam int USER_W  = 8;
    localparam int RED_LAT = 3;
    localparam int FIFO_D  = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*14-1:0]     req_a;
    logic [NREQ*14-1:0]     req_b;
    logic [NREQ*USER_W-1:0] req_user;
    logic signed [26:0]     prod_o;
    logic signed [13:0]     red_i;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic signed [13:0]     rsp_z;
    logic [PW-1:0]          rsp_port;
    logic [USER_W-1:0]      rsp_user;

    modmul15361_sched #(
        .NREQ(NREQ), .PW(PW), .USER_W(USER_W),
        .RED_LAT(RED_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_user(req_user),
        .prod_o(prod_o), .red_i(red_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_port(rsp_port), .rsp_user(rsp_user)
    );

    always #5 clk = ~clk;

    int nChk = 0;
    int nPass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        nChk++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // centred residue in [-7680, 7680]
    function automatic int modRed(input longint p);
        longint r;
        r = p % 15361;
        if (r > 7680) r -= 15361;
        else if (r < -7680) r += 15361;
        return int'(r);
    endfunction

    // behavioural reduction unit
    logic signed [13:0] redPipe [RED_LAT];
    always @(posedge clk) begin
        redPipe[0] <= 14'(modRed(longint'(prod_o)));
        for (int k = 1; k < RED_LAT; k++) redPipe[k] <= redPipe[k-1];
    end
    assign red_i = redPipe[RED_LAT-1];

    // requester side
    logic [NREQ-1:0] vld = '0;
    int opA [NREQ];
    int opB [NREQ];
    int opU [NREQ];
    int genPct = 0;
    logic [NREQ-1:0] allow = '0;
    logic rspRand = 1'b0;
    logic rspFix = 1'b1;
    int dirSeq = 0;
    int seenSeq = 0;
    logic [NREQ-1:0] dirMask = '0;
    int dirA [NREQ];
    int dirB [NREQ];
    int dirU [NREQ];
    logic [NREQ-1:0] took = '0;

    assign req_valid = vld;

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_user = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*14 +: 14] = 14'(opA[i]);
            req_b[i*14 +: 14] = 14'(opB[i]);
            req_user[i*USER_W +: USER_W] = USER_W'(opU[i]);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (took[i]) vld[i] = 1'b0;
            if (dirSeq != seenSeq && dirMask[i]) begin
                vld[i] = 1'b1;
                opA[i] = dirA[i];
                opB[i] = dirB[i];
                opU[i] = dirU[i];
            end else if (!vld[i] && allow[i] &&
                         $urandom_range(99) < genPct) begin
                vld[i] = 1'b1;
                opA[i] = int'($urandom_range(15360)) - 7680;
                opB[i] = int'($urandom_range(15360)) - 7680;
                opU[i] = int'($urandom_range(255));
            end
        end
        seenSeq = dirSeq;
        rsp_ready = rspRand ? ($urandom_range(99) < 70) : rspFix;
    end

    // reference model state
    typedef struct { int z; int port; int user; } rsp_t;
    typedef struct { int cyc; int p; } prod_t;
    rsp_t  expQ [$];
    prod_t prodQ [$];
    int grantLog [$];
    int outst = 0;
    int mPtr = NREQ - 1;
    int cyc = 0;
    logic rstPrev = 1'b0;
    logic holdPrev = 1'b0;
    int prevZ, prevPort, prevUser;

    always @(posedge clk) cyc++;

    function automatic logic [NREQ-1:0] expGrant();
        logic [NREQ-1:0] g;
        int j;
        g = '0;
        if (outst >= FIFO_D) return g;
        for (int k = 1; k <= NREQ; k++) begin
            j = (mPtr + k) % NREQ;
            if (req_valid[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_z", int'(rsp_z), 0);
            chk("rst_rsp_port", int'(rsp_port), 0);
            chk("rst_rsp_user", int'(rsp_user), 0);
            if (rstPrev) chk("rst_prod_o", int'(prod_o), 0);
            expQ.delete();
            prodQ.delete();
            outst = 0;
            mPtr = NREQ - 1;
            took = '0;
            holdPrev = 1'b0;
        end else begin
            chk("grant", int'(req_ready), int'(expGrant()));
            if (prodQ.size() > 0 && prodQ[0].cyc == cyc) begin
                chk("prod_o", int'(prod_o), prodQ[0].p);
                void'(prodQ.pop_front());
            end
            if (holdPrev) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_z", int'(rsp_z), prevZ);
                chk("hold_port", int'(rsp_port), prevPort);
                chk("hold_user", int'(rsp_user), prevUser);
            end
            if (rsp_valid && rsp_ready) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    chk("rsp_z", int'(rsp_z), e.z);
                    chk("rsp_port", int'(rsp_port), e.port);
                    chk("rsp_user", int'(rsp_user), e.user);
                end
                outst--;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    expQ.push_back('{modRed(longint'(opA[i] * opB[i])),
                                     i, opU[i]});
                    prodQ.push_back('{cyc + 2, opA[i] * opB[i]});
                    grantLog.push_back(i);
                    mPtr = i;
                    outst++;
                end
            end
            took = req_valid & req_ready;
            holdPrev = rsp_valid && !rsp_ready;
            prevZ = int'(rsp_z);
            prevPort = int'(rsp_port);
            prevUser = int'(rsp_user);
        end
        rstPrev = rst;
    end

    // helpers
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic issueDir(input logic [NREQ-1:0] m,
                            input int a, input int b, input int u);
        dirMask = m;
        for (int i = 0; i < NREQ; i++) begin
            dirA[i] = a;
            dirB[i] = b;
            dirU[i] = u + i;
        end
        dirSeq++;
    endtask

    task automatic waitAccept(input int port, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_valid[port] && req_ready[port]) && n < 30);
        if (!(req_valid[port] && req_ready[port])) chk(tag, 0, 1);
    endtask

    task automatic waitRsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 30);
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic quiesce();
        genPct = 0;
        allow = '0;
        rspRand = 1'b0;
        rspFix = 1'b1;
        cycles(25);
    endtask

    task automatic runOne(input int a, input int b, input int expZ,
                          input string tag);
        int n;
        @(negedge clk);
        issueDir(4'b0001, a, b, 'h11);
        waitAccept(0, "t2_accept_timeout");
        waitRsp(n);
        chk(tag, int'(rsp_z), expZ);
    endtask

    initial begin
        int n;
        int base;
        int seen;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // single op: value, product timing and latency
        @(negedge clk);
        issueDir(4'b0001, 2, 3, 'h5A);
        waitAccept(0, "t1_accept_timeout");
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) chk("t1_prod_o", int'(prod_o), 6);
        end while (!rsp_valid && n < 20);
        chk("t1_latency", n - 1, 5);
        chk("t1_z", int'(rsp_z), 6);
        chk("t1_port", int'(rsp_port), 0);
        chk("t1_user", int'(rsp_user), 'h5A);

        // range corners
        runOne(7680, 7680, -3840, "t2_max_max");
        runOne(-7680, 7680, 3840, "t2_min_max");
        runOne(-1, -1, 1, "t2_neg_neg");

        // all ports streaming
        quiesce();
        doReset();
        base = grantLog.size();
        allow = '1;
        genPct = 100;
        cycles(14);
        chk("t3_count", grantLog.size() - base, 13);
        if (grantLog.size() - base >= 8)
            for (int k = 0; k < 8; k++)
                chk("t3_order", grantLog[base+k], k % NREQ);

        // backpressure fills exactly the credit window
        quiesce();
        rspFix = 1'b0;
        doReset();
        base = grantLog.size();
        allow = '1;
        genPct = 100;
        cycles(20);
        chk("t4_grants", grantLog.size() - base, FIFO_D);
        chk("t4_ready_zero", int'(req_ready), 0);
        rspFix = 1'b1;
        @(negedge clk);
        chk("t4_pop_cycle_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("t4_resume", int'(req_ready != '0), 1);
        cycles(30);

        // two sparse ports alternate
        quiesce();
        doReset();
        @(negedge clk);
        issueDir(4'b0010, 5, 6, 'h20);
        waitAccept(1, "t5_accept_timeout");
        @(posedge clk);
        #2;
        base = grantLog.size();
        allow = 4'b1010;
        genPct = 100;
        cycles(10);
        genPct = 0;
        chk("t5_count", int'(grantLog.size() - base >= 8), 1);
        if (grantLog.size() - base >= 8)
            for (int k = 0; k < 8; k++)
                chk("t5_order", grantLog[base+k], (k % 2 == 0) ? 3 : 1);

        // reset with ops in flight
        quiesce();
        doReset();
        base = grantLog.size();
        @(negedge clk);
        issueDir(4'b0111, 100, -5, 'h30);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (grantLog.size() < base + 3 && n < 20);
        chk("t6_issued", grantLog.size() - base, 3);
        doReset();
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("t6_no_rsp", seen, 0);
        issueDir(4'b0101, 9, 9, 'h40);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk("t6_first_grant", int'(req_ready), 1);
        waitRsp(n);
        chk("t6_latency", n - 1, 5);
        chk("t6_z", int'(rsp_z), 81);
        chk("t6_port", int'(rsp_port), 0);

        // random traffic with random backpressure
        quiesce();
        doReset();
        allow = '1;
        genPct = 50;
        rspRand = 1'b1;
        cycles(600);
        quiesce();
        chk("drain_empty", expQ.size(), 0);
        chk("drain_credit", outst, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
